// File: rtl/reaction_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reaction_round_ctrl
// Purpose  : Reaction-game round sequencer. It drives the timer, judges each
//            round as a hit or a miss, and tracks score, lives and difficulty.
// Revision : 1.0 - initial release
// ============================================================================
module reaction_round_ctrl #(
    parameter int unsigned CLKS_PER_MS    = 50000,
    parameter int unsigned GAP_MS         = 500,
    parameter int unsigned END_VALUE      = 1000,
    parameter int unsigned HITS_PER_LEVEL = 5,
    parameter int unsigned START_LIVES    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hit,
    input  logic [11:0] timer_value,
    input  logic        end_reached,
    output logic        timer_reset,
    output logic        timer_enable,
    output logic [1:0]  timer_difficulty,
    output logic [11:0] timer_end_value,
    output logic        round_active,
    output logic [7:0]  score,
    output logic [1:0]  lives,
    output logic [11:0] last_time,
    output logic [11:0] best_time,
    output logic        game_over
);

    localparam int unsigned GAP_CYCLES = GAP_MS * CLKS_PER_MS;
    localparam int unsigned GAP_W      = $clog2(GAP_CYCLES + 1);
    localparam int unsigned HIT_W      = $clog2(HITS_PER_LEVEL + 1);

    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [HIT_W-1:0] HIT_LAST  = HIT_W'(HITS_PER_LEVEL - 1);
    localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);
    localparam logic [1:0]       LEVEL_MAX  = 2'd2;
    localparam logic [11:0]      BEST_INIT  = 12'hFFF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_RUN  = 3'd2,
        S_GAP  = 3'd3,
        S_OVER = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic [1:0]         level_q, level_d;
    logic [HIT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [11:0]        best_q, best_d;
    logic [11:0]        last_q, last_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               timer_reset_q, timer_enable_q, round_active_q, game_over_q;

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        lives_d   = lives_q;
        level_d   = level_q;
        hit_cnt_d = hit_cnt_q;
        best_d    = best_q;
        last_d    = last_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    lives_d   = LIVES_INIT;
                    score_d   = 8'd0;
                    level_d   = 2'd0;
                    hit_cnt_d = '0;
                    best_d    = BEST_INIT;
                    last_d    = 12'd0;
                    state_d   = S_ARM;
                end
            end
            S_ARM: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // A press in the same cycle as the timeout still scores.
                if (hit) begin
                    last_d = timer_value;
                    if (timer_value < best_q) begin
                        best_d = timer_value;
                    end
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                    if (hit_cnt_q == HIT_LAST) begin
                        hit_cnt_d = '0;
                        if (level_q != LEVEL_MAX) begin
                            level_d = level_q + 2'd1;
                        end
                    end else begin
                        hit_cnt_d = hit_cnt_q + HIT_W'(1);
                    end
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else if (end_reached) begin
                    if (lives_q <= 2'd1) begin
                        lives_d = 2'd0;
                        state_d = S_OVER;
                    end else begin
                        lives_d   = lives_q - 2'd1;
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_ARM;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            score_q        <= 8'd0;
            lives_q        <= 2'd0;
            level_q        <= 2'd0;
            hit_cnt_q      <= '0;
            best_q         <= BEST_INIT;
            last_q         <= 12'd0;
            gap_cnt_q      <= '0;
            timer_reset_q  <= 1'b0;
            timer_enable_q <= 1'b0;
            round_active_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            score_q        <= score_d;
            lives_q        <= lives_d;
            level_q        <= level_d;
            hit_cnt_q      <= hit_cnt_d;
            best_q         <= best_d;
            last_q         <= last_d;
            gap_cnt_q      <= gap_cnt_d;
            timer_reset_q  <= (state_d == S_ARM);
            timer_enable_q <= (state_d == S_ARM) || (state_d == S_RUN);
            round_active_q <= (state_d == S_RUN);
            game_over_q    <= (state_d == S_OVER);
        end
    end

    // Level only moves on the edge leaving RUN or at game load, never in ARM/RUN.
    assign timer_difficulty = level_q;
    assign timer_end_value  = 12'(END_VALUE);
    assign timer_reset      = timer_reset_q;
    assign timer_enable     = timer_enable_q;
    assign round_active     = round_active_q;
    assign score            = score_q;
    assign lives            = lives_q;
    assign last_time        = last_q;
    assign best_time        = best_q;
    assign game_over        = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_reaction_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_reaction_round_ctrl
// Purpose  : Self-checking bench for reaction_round_ctrl with a score model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reaction_round_ctrl;

    localparam int C_GAP_CYC = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        hit = 1'b0;
    logic [11:0] timer_value = 12'd0;
    logic        end_reached = 1'b0;
    logic        timer_reset, timer_enable, round_active, game_over;
    logic [1:0]  timer_difficulty, lives;
    logic [11:0] timer_end_value, last_time, best_time;
    logic [7:0]  score;

    int checks = 0;
    int errors = 0;

    // Reference game state
    int m_score, m_lives, m_level, m_hits, m_best, m_last;

    reaction_round_ctrl #(
        .CLKS_PER_MS(10), .GAP_MS(2), .END_VALUE(100),
        .HITS_PER_LEVEL(2), .START_LIVES(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .hit(hit),
        .timer_value(timer_value), .end_reached(end_reached),
        .timer_reset(timer_reset), .timer_enable(timer_enable),
        .timer_difficulty(timer_difficulty), .timer_end_value(timer_end_value),
        .round_active(round_active), .score(score), .lives(lives),
        .last_time(last_time), .best_time(best_time), .game_over(game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int lv, input int bst);
        m_score = 0; m_lives = lv; m_level = 0; m_hits = 0; m_best = bst; m_last = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_score"}, 32'(score), m_score);
        chk({tag, "_lives"}, 32'(lives), m_lives);
        chk({tag, "_level"}, 32'(timer_difficulty), m_level);
        chk({tag, "_best"},  32'(best_time), m_best);
        chk({tag, "_last"},  32'(last_time), m_last);
        chk({tag, "_endv"},  32'(timer_end_value), 100);
    endtask

    task automatic check_reset(input string tag);
        model_clear(0, 'hFFF);
        check_model(tag);
        chk({tag, "_treset"}, 32'(timer_reset), 0);
        chk({tag, "_tenable"}, 32'(timer_enable), 0);
        chk({tag, "_active"}, 32'(round_active), 0);
        chk({tag, "_over"}, 32'(game_over), 0);
    endtask

    task automatic start_game;
        start = 1'b1;
        tick;
        start = 1'b0;
        model_clear(3, 'hFFF);
        check_model("start");
        chk("arm_treset", 32'(timer_reset), 1);
        chk("arm_active", 32'(round_active), 0);
        chk("arm_over", 32'(game_over), 0);
        tick;
        chk("run_treset", 32'(timer_reset), 0);
        chk("run_active", 32'(round_active), 1);
        chk("run_enable", 32'(timer_enable), 1);
    endtask

    // From the cycle after the round ends, count cycles until the next arm pulse.
    task automatic gap_and_arm(input bit poke_hit);
        int n = 0;
        while (timer_reset !== 1'b1 && n < 100) begin
            if (poke_hit && n == 5) hit = 1'b1;
            tick;
            hit = 1'b0;
            n++;
        end
        chk("gap_len", n, C_GAP_CYC);
        check_model("gap");
        chk("gap_arm_enable", 32'(timer_enable), 1);
        tick;
        chk("gap_run_active", 32'(round_active), 1);
        chk("gap_run_treset", 32'(timer_reset), 0);
    endtask

    task automatic hit_round(input int tv, input bit with_end);
        chk("pre_hit_level", 32'(timer_difficulty), m_level);
        timer_value = 12'(tv);
        hit = 1'b1;
        end_reached = with_end;
        tick;
        hit = 1'b0;
        end_reached = 1'b0;
        m_score = (m_score < 255) ? m_score + 1 : 255;
        m_last  = tv;
        if (tv < m_best) m_best = tv;
        m_hits++;
        if (m_hits == 2) begin
            m_hits = 0;
            if (m_level < 2) m_level++;
        end
        check_model("hit");
        chk("hit_active", 32'(round_active), 0);
        chk("hit_enable", 32'(timer_enable), 0);
    endtask

    task automatic miss_round;
        timer_value = 12'(100);
        end_reached = 1'b1;
        tick;
        end_reached = 1'b0;
        m_lives--;
        check_model("miss");
        chk("miss_enable", 32'(timer_enable), 0);
        chk("miss_active", 32'(round_active), 0);
        chk("miss_over", 32'(game_over), (m_lives == 0) ? 1 : 0);
    endtask

    initial begin
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        check_reset("rst");

        hit = 1'b1;
        tick;
        hit = 1'b0;
        check_reset("idle_hit");

        start_game;
        hit_round(37, 1'b0);
        gap_and_arm(1'b1);
        hit_round(52, 1'b0);
        chk("level_after_two", 32'(timer_difficulty), 1);
        gap_and_arm(1'b0);

        for (int i = 0; i < 4; i++) begin
            hit_round(int'($urandom_range(1, 999)), (i == 2));
            gap_and_arm(i == 1);
        end
        chk("level_sat", 32'(timer_difficulty), 2);

        miss_round;
        gap_and_arm(1'b0);
        miss_round;
        gap_and_arm(1'b0);
        miss_round;

        hit = 1'b1;
        timer_value = 12'd5;
        tick;
        hit = 1'b0;
        tick;
        tick;
        check_model("over_hold");
        chk("over_flag", 32'(game_over), 1);
        chk("over_enable", 32'(timer_enable), 0);

        start_game;
        hit_round(int'($urandom_range(1, 999)), 1'b0);
        gap_and_arm(1'b0);

        timer_value = 12'd9;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_reset("mid_rst");

        start_game;
        hit_round(int'($urandom_range(1, 999)), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
